valu_addc_lane_seq: RTL and testbench

- Wave-level sequencer for the Vector ALU integer add path. Accepts one lane's operand pair per cycle and drives it through a 2-stage pipeline around the 32-bit carry-select adder.
- Emits per-lane sums to the VGPR write-back stage with a valid/ready handshake.
- Assembles the per-lane carry/borrow bits into a VCC mask for V_ADD_CO / V_SUB_CO / V_ADDC_CO / V_SUBB_CO.

---
 rtl/valu_addc_lane_seq.sv | 178 +++++++++++++++++
 tb/tb_valu_addc_lane_seq.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/valu_addc_lane_seq.sv
// valu_addc_lane_seq
//   Wave-level sequencer for the VALU integer add path. Takes one lane's
//   operand pair per cycle (lanes 0..LANES-1 in order), runs it through a
//   two-stage pipeline (operand condition -> WIDTH+1 bit add) and streams
//   per-lane sums to write-back. The per-lane carry/borrow bits are
//   gathered into a VCC mask for V_ADD_CO / V_SUB_CO / V_ADDC_CO / V_SUBB_CO.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   start               begin a wave (only honoured in IDLE); latches op/exec/vcc_in
//   op                  0=ADD_CO 1=SUB_CO 2=ADDC_CO 3=SUBB_CO
//   exec, vcc_in        execute mask and carry/borrow-in mask for the wave
//   in_valid/in_ready   operand handshake, in_a/in_b operands
//   out_valid/out_ready result handshake, out_lane/out_sum/out_we result
//   vcc_out             carry/borrow mask, held after the wave until next start
//   done                one-cycle pulse when vcc_out is complete
//   busy                sequencer is not idle
//   clamp               (VALU_ADD_CLAMP_EN only) saturate instead of wrap
//
// Optional feature macro: VALU_ADD_CLAMP_EN
module valu_addc_lane_seq #(
    parameter int WIDTH = 32,
    parameter int LANES = 32,
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [LANES-1:0] exec,
    input  logic [LANES-1:0] vcc_in,
`ifdef VALU_ADD_CLAMP_EN
    input  logic             clamp,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LW-1:0]    out_lane,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_we,
    output logic [LANES-1:0] vcc_out,
    output logic             done,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic [1:0]       op_q;
    logic [LANES-1:0] exec_q;
    logic [LANES-1:0] vcc_q;
    logic [LW-1:0]    cnt;
`ifdef VALU_ADD_CLAMP_EN
    logic             clamp_q;
`endif

    // stage 1 registers
    logic             s1_vld;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_cin;
    logic [LW-1:0]    s1_lane;

    logic             en;
    logic             in_fire;
    logic             out_fire;
    logic [WIDTH-1:0] b_sel;
    logic             cin_sel;
    logic [WIDTH:0]   full;
    logic             res_bit;
    logic [WIDTH-1:0] sum_sel;

    // Single global stall: nothing moves while a result is waiting.
    assign en       = ~out_valid | out_ready;
    assign in_ready = (state == RUN) & en;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign busy     = (state != IDLE);

    // Subtract is a + ~b + 1; subtract-with-borrow uses ~borrow_in as the carry.
    always_comb begin
        b_sel   = op_q[0] ? ~in_b : in_b;
        cin_sel = 1'b0;
        case (op_q)
            2'd0: cin_sel = 1'b0;
            2'd1: cin_sel = 1'b1;
            2'd2: cin_sel = vcc_q[cnt];
            2'd3: cin_sel = ~vcc_q[cnt];
            default: cin_sel = 1'b0;
        endcase
    end

    // Carry-out of a + ~b + cin is the inverse of the borrow.
    always_comb begin
        full    = {1'b0, s1_a} + {1'b0, s1_b} + {{WIDTH{1'b0}}, s1_cin};
        res_bit = op_q[0] ? ~full[WIDTH] : full[WIDTH];
`ifdef VALU_ADD_CLAMP_EN
        if (clamp_q && res_bit)
            sum_sel = op_q[0] ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
        else
            sum_sel = full[WIDTH-1:0];
`else
        sum_sel = full[WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= 2'd0;
            exec_q    <= '0;
            vcc_q     <= '0;
            cnt       <= '0;
`ifdef VALU_ADD_CLAMP_EN
            clamp_q   <= 1'b0;
`endif
            s1_vld    <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_cin    <= 1'b0;
            s1_lane   <= '0;
            out_valid <= 1'b0;
            out_lane  <= '0;
            out_sum   <= '0;
            out_we    <= 1'b0;
            vcc_out   <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state   <= RUN;
                    op_q    <= op;
                    exec_q  <= exec;
                    vcc_q   <= vcc_in;
                    cnt     <= '0;
                    vcc_out <= '0;
`ifdef VALU_ADD_CLAMP_EN
                    clamp_q <= clamp;
`endif
                end
                RUN:   if (in_fire && cnt == LW'(LANES - 1)) state <= DRAIN;
                DRAIN: if (out_fire && out_lane == LW'(LANES - 1)) begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE:  state <= IDLE;
                default: state <= IDLE;
            endcase

            if (in_fire)
                cnt <= cnt + 1'b1;

            if (en) begin
                s1_vld <= in_fire;
                if (in_fire) begin
                    s1_a    <= in_a;
                    s1_b    <= b_sel;
                    s1_cin  <= cin_sel;
                    s1_lane <= cnt;
                end
                if (s1_vld) begin
                    out_valid         <= 1'b1;
                    out_sum           <= sum_sel;
                    out_lane          <= s1_lane;
                    out_we            <= exec_q[s1_lane];
                    vcc_out[s1_lane]  <= exec_q[s1_lane] & res_bit;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_valu_addc_lane_seq.sv
module tb_valu_addc_lane_seq;
    localparam int WIDTH = 32;
    localparam int LANES = 32;
    localparam int LW    = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       op = 2'd0;
    logic [LANES-1:0] exec = '0;
    logic [LANES-1:0] vcc_in = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [LW-1:0]    out_lane;
    logic [WIDTH-1:0] out_sum;
    logic             out_we;
    logic [LANES-1:0] vcc_out;
    logic             done;
    logic             busy;

    valu_addc_lane_seq #(.WIDTH(WIDTH), .LANES(LANES)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .exec(exec), .vcc_in(vcc_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_lane(out_lane),
        .out_sum(out_sum), .out_we(out_we), .vcc_out(vcc_out), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // operand tables and model results
    logic [WIDTH-1:0] ta [LANES];
    logic [WIDTH-1:0] tbv[LANES];
    logic [WIDTH-1:0] exp_sum[LANES];
    logic             exp_we [LANES];
    logic [LANES-1:0] exp_mask;

    // Plain arithmetic model: add with carry-out, or subtract with borrow-out.
    task automatic model(input logic [1:0] o, input logic [LANES-1:0] ex, input logic [LANES-1:0] vin);
        exp_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            logic [WIDTH:0] ci;
            logic [WIDTH:0] full;
            logic           bitv;
            ci = (o[1]) ? {{WIDTH{1'b0}}, vin[i]} : '0;
            if (!o[0]) begin
                full = {1'b0, ta[i]} + {1'b0, tbv[i]} + ci;
                exp_sum[i] = full[WIDTH-1:0];
                bitv = full[WIDTH];
            end else begin
                exp_sum[i] = ta[i] - tbv[i] - ci[WIDTH-1:0];
                bitv = ({1'b0, ta[i]} < ({1'b0, tbv[i]} + ci));
            end
            exp_we[i] = ex[i];
            exp_mask[i] = ex[i] & bitv;
        end
    endtask

    task automatic clear_tables();
        for (int i = 0; i < LANES; i++) begin
            ta[i] = '0;
            tbv[i] = '0;
        end
    endtask

    // Compare process: checks every result handshake and stall cycle.
    bit          cmp_en = 1'b0;
    int          exp_lane = 0;
    int          hs_cyc = -10;
    bit          prev_stall = 1'b0;
    logic [LW-1:0] prev_lane = '0;
    logic [WIDTH-1:0] prev_sum = '0;
    int          done_seen = 0;

    always begin
        @(negedge clk);
        #2;
        if (done) done_seen++;
        if (!rst && cmp_en) begin
            if (prev_stall) begin
                chk("stall_hold_valid", out_valid, 1'b1);
                chk("stall_hold_lane", out_lane, prev_lane);
                chk("stall_hold_sum", out_sum, prev_sum);
            end
            if (out_valid && out_ready) begin
                chk("lane_order", out_lane, exp_lane[LW-1:0]);
                if (exp_lane < LANES) begin
                    chk("sum", out_sum, exp_sum[exp_lane]);
                    chk("we", out_we, exp_we[exp_lane]);
                end
                if (exp_lane == LANES - 1) hs_cyc = cyc;
                exp_lane++;
            end
            if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 1'b0);
            if (done) begin
                chk("done_after_last", exp_lane, LANES);
                chk("done_timing", cyc, hs_cyc + 1);
            end
            prev_stall = out_valid && !out_ready;
            prev_lane  = out_lane;
            prev_sum   = out_sum;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_lane"}, out_lane, 0);
        chk({tag, "_out_sum"}, out_sum, 0);
        chk({tag, "_out_we"}, out_we, 0);
        chk({tag, "_vcc_out"}, vcc_out, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Drive one wave. stall_lane: hold out_ready low 5 cycles there (-1 none).
    // rst_lane: pulse reset when that lane is being presented (-1 none).
    task automatic run_wave(input logic [1:0] o, input logic [LANES-1:0] ex,
                            input logic [LANES-1:0] vin, input int stall_lane, input int rst_lane);
        int idx, stall_left, guard, g, d0;
        bit stalled, bubbled, sp, fire, aborted;
        model(o, ex, vin);
        exp_lane = 0;
        hs_cyc = -10;
        cmp_en = 1'b1;
        @(negedge clk);
        start = 1'b1; op = o; exec = ex; vcc_in = vin; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1 chk("busy_after_start", busy, 1'b1);
        idx = 0; stall_left = 0; guard = 0;
        stalled = 0; bubbled = 0; sp = 0; aborted = 0;
        while (idx < LANES && guard < 500) begin
            if (idx == rst_lane) begin
                d0 = done_seen;
                cmp_en = 1'b0;
                in_valid = 1'b1; in_a = ta[idx]; in_b = tbv[idx];
                #3 rst = 1'b1;
                #1 chk_zero_outputs("midreset");
                @(negedge clk);
                rst = 1'b0;
                in_valid = 1'b0;
                repeat (6) @(negedge clk);
                chk("abort_no_done", done_seen, d0);
                chk("abort_idle", busy, 1'b0);
                aborted = 1;
                break;
            end
            if (idx == stall_lane && !stalled) begin
                stall_left = 5;
                stalled = 1;
            end
            out_ready = (stall_left == 0);
            in_valid = 1'b1;
            if (idx == 3 && !bubbled) begin
                in_valid = 1'b0;
                bubbled = 1;
            end
            // start while busy with a different op must be ignored
            if (idx == 5 && !sp) begin
                start = 1'b1;
                op = ~o;
                exec = ~ex;
                sp = 1;
            end
            in_a = ta[idx];
            in_b = tbv[idx];
            #1 fire = in_valid & in_ready;
            @(negedge clk);
            start = 1'b0; op = o; exec = ex;
            if (fire) idx++;
            if (stall_left > 0) stall_left--;
            guard++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        if (!aborted) begin
            chk("feed_timeout", (guard < 500), 1'b1);
            g = 0;
            #3;
            while (!done && g < 100) begin
                @(negedge clk);
                #3;
                g++;
            end
            chk("done_timeout", (g < 100), 1'b1);
            chk("vcc_out_model", vcc_out, exp_mask);
            repeat (3) @(negedge clk);
            #3;
            chk("vcc_out_held", vcc_out, exp_mask);
            chk("idle_after_done", busy, 1'b0);
            chk("lanes_out", exp_lane, LANES);
        end
        cmp_en = 1'b0;
    endtask

    initial begin
        // reset values
        repeat (3) @(negedge clk);
        #1 chk_zero_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        // in_valid while idle is not accepted
        in_valid = 1'b1;
        #1 chk("idle_in_ready", in_ready, 1'b0);
        in_valid = 1'b0;

        // ADD_CO basic with wrap on lane 2
        clear_tables();
        ta[0] = 32'd10;         tbv[0] = 32'd1;
        ta[1] = 32'd200;        tbv[1] = 32'd6969;
        ta[2] = 32'hFFFF_FFFF;  tbv[2] = 32'd1;
        model(2'd0, '1, '0);
        chk("pin_add_s0", exp_sum[0], 32'd11);
        chk("pin_add_s1", exp_sum[1], 32'd7169);
        chk("pin_add_s2", exp_sum[2], 32'd0);
        chk("pin_add_mask", exp_mask, 32'h0000_0004);
        run_wave(2'd0, '1, '0, -1, -1);
        chk("add_vcc_literal", vcc_out, 32'h0000_0004);

        // SUB_CO
        clear_tables();
        ta[0] = 32'd5; tbv[0] = 32'd7;
        ta[1] = 32'd7; tbv[1] = 32'd5;
        model(2'd1, '1, '0);
        chk("pin_sub_s0", exp_sum[0], 32'hFFFF_FFFE);
        chk("pin_sub_s1", exp_sum[1], 32'd2);
        run_wave(2'd1, '1, '0, -1, -1);
        chk("sub_vcc_literal", vcc_out, 32'h0000_0001);

        // ADDC_CO with carry-in on lane 0 only
        clear_tables();
        ta[0] = 32'hFFFF_FFFF; tbv[0] = 32'd0;
        ta[1] = 32'hFFFF_FFFF; tbv[1] = 32'd0;
        model(2'd2, '1, 32'h1);
        chk("pin_addc_s0", exp_sum[0], 32'd0);
        chk("pin_addc_s1", exp_sum[1], 32'hFFFF_FFFF);
        run_wave(2'd2, '1, 32'h1, -1, -1);
        chk("addc_vcc_literal", vcc_out, 32'h0000_0001);

        // SUBB_CO with borrow-in on lane 0 only
        clear_tables();
        ta[0] = 32'd5; tbv[0] = 32'd5;
        ta[1] = 32'd5; tbv[1] = 32'd5;
        ta[2] = 32'd9; tbv[2] = 32'd3;
        model(2'd3, '1, 32'h1);
        chk("pin_subb_s0", exp_sum[0], 32'hFFFF_FFFF);
        chk("pin_subb_s2", exp_sum[2], 32'd6);
        run_wave(2'd3, '1, 32'h1, -1, -1);
        chk("subb_vcc_literal", vcc_out, 32'h0000_0001);

        // inactive lane 0 carries but must not appear in vcc or write back
        clear_tables();
        ta[0] = 32'hFFFF_FFFF; tbv[0] = 32'd1;
        ta[1] = 32'hFFFF_FFFF; tbv[1] = 32'd1;
        run_wave(2'd0, 32'hFFFF_FFFE, '0, -1, -1);
        chk("exec_vcc_literal", vcc_out, 32'h0000_0002);

        // backpressure mid-wave with mixed operands
        for (int i = 0; i < LANES; i++) begin
            ta[i]  = 32'h8000_0000 + 32'(i * 32'h0123_4567);
            tbv[i] = 32'h7FFF_FFF0 + 32'(i * 3);
        end
        run_wave(2'd0, 32'h5A5A_A5A5, '0, 12, -1);

        // reset during lane 10, then a full wave afterwards
        run_wave(2'd1, '1, '0, -1, 10);
        for (int i = 0; i < LANES; i++) begin
            ta[i]  = 32'(i * 7);
            tbv[i] = 32'(i * 5 + (i % 3) * 9);
        end
        run_wave(2'd3, '1, 32'hF0F0_1234, 20, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=0", cyc);
        $fatal(1, "timeout");
    end

endmodule
